// File: rtl/accu_bank.sv
// Bank of NUM_ACC independent WIDTH-bit accumulators with load/add/sub/clear,
// optional signed saturation, sticky overflow flags and a registered read port.
module accu_bank #(
  parameter  int WIDTH    = 16,
  parameter  int NUM_ACC  = 4,
  parameter  int SATURATE = 0,
  localparam int SEL_W    = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [WIDTH-1:0] data_out,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             op_done
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_CLR  = 3'b100
  } op_e;

  localparam logic [SEL_W:0] NUM_L = (SEL_W + 1)'(NUM_ACC);

  logic [WIDTH-1:0]   r_acc [NUM_ACC];
  logic [NUM_ACC-1:0] r_ovf;
  logic [WIDTH-1:0]   r_data_out;
  logic               r_zero;
  logic               r_neg;
  logic               r_ovf_out;
  logic               r_op_done;

  op_e                w_op;
  logic               w_wr_ok;
  logic               w_rd_ok;
  logic               w_accept;
  logic [SEL_W-1:0]   w_wr_idx;
  logic [SEL_W-1:0]   w_rd_idx;
  logic [WIDTH-1:0]   w_cur;
  logic               w_cur_ovf;
  logic [WIDTH-1:0]   w_res;
  logic               w_arith_ovf;
  logic [WIDTH-1:0]   w_next;
  logic               w_next_ovf;
  logic [WIDTH-1:0]   w_rd_val;
  logic               w_rd_ovf;

  assign w_op     = op_e'(op);
  assign w_wr_ok  = ({1'b0, wr_sel} < NUM_L);
  assign w_rd_ok  = ({1'b0, rd_sel} < NUM_L);
  assign w_accept = ce && op_valid && w_wr_ok;

  // Out-of-range selects are steered to entry 0 so no access leaves the array.
  assign w_wr_idx  = w_wr_ok ? wr_sel : '0;
  assign w_rd_idx  = w_rd_ok ? rd_sel : '0;
  assign w_cur     = r_acc[w_wr_idx];
  assign w_cur_ovf = r_ovf[w_wr_idx];
  assign w_rd_val  = w_rd_ok ? r_acc[w_rd_idx] : '0;
  assign w_rd_ovf  = w_rd_ok ? r_ovf[w_rd_idx] : 1'b0;

  always_comb begin
    w_next      = w_cur;
    w_next_ovf  = w_cur_ovf;
    w_res       = '0;
    w_arith_ovf = 1'b0;
    case (w_op)
      OP_LOAD: w_next = data_in;
      OP_CLR: begin
        w_next     = '0;
        w_next_ovf = 1'b0;
      end
      OP_ADD, OP_SUB: begin
        // Signed overflow only needs the operand and result sign bits, so the
        // carry out of the WIDTH-bit sum is never formed.
        if (w_op == OP_ADD) begin
          w_res       = w_cur + data_in;
          w_arith_ovf = (w_cur[WIDTH-1] == data_in[WIDTH-1]) &&
                        (w_res[WIDTH-1] != w_cur[WIDTH-1]);
        end else begin
          w_res       = w_cur - data_in;
          w_arith_ovf = (w_cur[WIDTH-1] != data_in[WIDTH-1]) &&
                        (w_res[WIDTH-1] != w_cur[WIDTH-1]);
        end
        w_next = w_res;
        if (w_arith_ovf) begin
          w_next_ovf = 1'b1;
          if (SATURATE != 0) begin
            w_next = w_cur[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NUM_ACC; k++) r_acc[k] <= '0;
      r_ovf      <= '0;
      r_data_out <= '0;
      r_zero     <= 1'b1;
      r_neg      <= 1'b0;
      r_ovf_out  <= 1'b0;
      r_op_done  <= 1'b0;
    end else if (ce) begin
      r_data_out <= w_rd_val;
      r_zero     <= (w_rd_val == '0);
      r_neg      <= w_rd_val[WIDTH-1];
      r_ovf_out  <= w_rd_ovf;
      r_op_done  <= w_accept;
      if (w_accept) begin
        r_acc[w_wr_idx] <= w_next;
        r_ovf[w_wr_idx] <= w_next_ovf;
      end
    end
  end

  assign data_out = r_data_out;
  assign zero     = r_zero;
  assign neg      = r_neg;
  assign ovf      = r_ovf_out;
  assign op_done  = r_op_done;

endmodule

// File: tb/tb_accu_bank.sv
// Scoreboard bench for accu_bank: a wrapping and a saturating instance share
// stimulus and are checked against an integer-arithmetic reference model.
module tb_accu_bank;

  localparam int W  = 16;
  localparam int NA = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic          op_valid;
  logic [2:0]    op;
  logic [1:0]    wr_sel;
  logic [W-1:0]  data_in;
  logic [1:0]    rd_sel;

  logic [W-1:0]  do_w, do_s;
  logic          z_w, z_s, n_w, n_s, o_w, o_s, dn_w, dn_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  accu_bank #(.WIDTH(W), .NUM_ACC(NA), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .ce(ce), .op_valid(op_valid), .op(op),
    .wr_sel(wr_sel), .data_in(data_in), .rd_sel(rd_sel),
    .data_out(do_w), .zero(z_w), .neg(n_w), .ovf(o_w), .op_done(dn_w)
  );

  accu_bank #(.WIDTH(W), .NUM_ACC(NA), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .ce(ce), .op_valid(op_valid), .op(op),
    .wr_sel(wr_sel), .data_in(data_in), .rd_sel(rd_sel),
    .data_out(do_s), .zero(z_s), .neg(n_s), .ovf(o_s), .op_done(dn_s)
  );

  typedef struct {
    logic [W-1:0] d [2];
    logic         z [2];
    logic         n [2];
    logic         o [2];
    logic         done;
  } exp_t;

  exp_t sb_q [$];

  // Reference state: index 0 = wrapping instance, 1 = saturating instance.
  logic [W-1:0] m_acc [2][NA];
  logic         m_ovf [2][NA];
  exp_t         e_cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic apply_op(input int d);
    int a, b, r;
    case (op)
      3'd1: m_acc[d][wr_sel] = data_in;
      3'd2, 3'd3: begin
        a = int'($signed(m_acc[d][wr_sel]));
        b = int'($signed(data_in));
        r = (op == 3'd2) ? a + b : a - b;
        if (r > 32767 || r < -32768) begin
          m_ovf[d][wr_sel] = 1'b1;
          if (d == 1) r = (r > 0) ? 32767 : -32768;
        end
        m_acc[d][wr_sel] = r[15:0];
      end
      3'd4: begin
        m_acc[d][wr_sel] = '0;
        m_ovf[d][wr_sel] = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic model_edge();
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < NA; k++) begin
          m_acc[d][k] = '0;
          m_ovf[d][k] = 1'b0;
        end
        e_cur.d[d] = '0; e_cur.z[d] = 1'b1; e_cur.n[d] = 1'b0; e_cur.o[d] = 1'b0;
      end
      e_cur.done = 1'b0;
    end else if (ce) begin
      for (int d = 0; d < 2; d++) begin
        if (rd_sel < NA) begin
          e_cur.d[d] = m_acc[d][rd_sel];
          e_cur.o[d] = m_ovf[d][rd_sel];
        end else begin
          e_cur.d[d] = '0;
          e_cur.o[d] = 1'b0;
        end
        e_cur.z[d] = (e_cur.d[d] == '0);
        e_cur.n[d] = e_cur.d[d][W-1];
      end
      e_cur.done = op_valid && (wr_sel < NA);
      if (e_cur.done) for (int d = 0; d < 2; d++) apply_op(d);
    end
    sb_q.push_back(e_cur);
  endtask

  task automatic step(input logic r, input logic c, input logic v, input logic [2:0] o,
                      input logic [1:0] ws, input logic [W-1:0] din, input logic [1:0] rs);
    rst = r; ce = c; op_valid = v; op = o; wr_sel = ws; data_in = din; rd_sel = rs;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: every edge produces a registered response, compared one half cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("wrap.data_out", 32'(do_w), 32'(e.d[0]));
        chk("wrap.zero",     32'(z_w),  32'(e.z[0]));
        chk("wrap.neg",      32'(n_w),  32'(e.n[0]));
        chk("wrap.ovf",      32'(o_w),  32'(e.o[0]));
        chk("wrap.op_done",  32'(dn_w), 32'(e.done));
        chk("sat.data_out",  32'(do_s), 32'(e.d[1]));
        chk("sat.zero",      32'(z_s),  32'(e.z[1]));
        chk("sat.neg",       32'(n_s),  32'(e.n[1]));
        chk("sat.ovf",       32'(o_s),  32'(e.o[1]));
        chk("sat.op_done",   32'(dn_s), 32'(e.done));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] din;
    // reset held with an active LOAD, then idle
    repeat (2) step(1'b0, 1'b1, 1'b1, 3'd1, 2'd2, 16'hABCD, 2'd2);
    step(1'b1, 1'b1, 1'b0, 3'd1, 2'd0, 16'h5555, 2'd0);
    step(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd1);
    // load / add / sub on accu[2]
    step(1'b1, 1'b1, 1'b1, 3'd1, 2'd2, 16'h1234, 2'd2);
    step(1'b1, 1'b1, 1'b1, 3'd2, 2'd2, 16'h0011, 2'd2);
    step(1'b1, 1'b1, 1'b1, 3'd3, 2'd2, 16'h0045, 2'd2);
    repeat (2) step(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd2);
    // positive overflow, sticky through LOAD, cleared by CLR
    step(1'b1, 1'b1, 1'b1, 3'd1, 2'd0, 16'h7FFF, 2'd0);
    step(1'b1, 1'b1, 1'b1, 3'd2, 2'd0, 16'h0001, 2'd0);
    step(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd0);
    step(1'b1, 1'b1, 1'b1, 3'd1, 2'd0, 16'h0005, 2'd0);
    step(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd0);
    step(1'b1, 1'b1, 1'b1, 3'd4, 2'd0, 16'h0000, 2'd0);
    repeat (2) step(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd0);
    // negative overflow on accu[1]
    step(1'b1, 1'b1, 1'b1, 3'd1, 2'd1, 16'h8000, 2'd1);
    step(1'b1, 1'b1, 1'b1, 3'd3, 2'd1, 16'h0001, 2'd1);
    repeat (2) step(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd1);
    // clock enable, out-of-range selects, reserved opcode
    step(1'b1, 1'b0, 1'b1, 3'd2, 2'd1, 16'h0100, 2'd1);
    step(1'b1, 1'b1, 1'b1, 3'd2, 2'd1, 16'h0100, 2'd1);
    repeat (2) step(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd2);
    step(1'b1, 1'b1, 1'b1, 3'd1, 2'd3, 16'hFFFF, 2'd3);
    step(1'b1, 1'b1, 1'b1, 3'd6, 2'd1, 16'hFFFF, 2'd1);
    step(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd1);
    // reset coinciding with an accepted ADD
    step(1'b1, 1'b1, 1'b1, 3'd1, 2'd2, 16'h0042, 2'd2);
    step(1'b0, 1'b1, 1'b1, 3'd2, 2'd2, 16'h0001, 2'd2);
    repeat (2) step(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd2);
    // randomized traffic biased toward overflow boundaries
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0:       din = 16'h7FFF;
        1:       din = 16'h8000;
        2:       din = 16'h0001;
        3:       din = 16'hFFFF;
        default: din = 16'($urandom);
      endcase
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), din, 2'($urandom_range(0, 3)));
    end
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
